// File: rtl/ntt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ntt_ctrl
// Purpose  : Single-BFU sequencer for in-place 256-point NTT/INTT (Kyber/Dilithium)
// Revision : 1.0
// ============================================================================
module ntt_ctrl #(
  parameter int N        = 256,
  parameter int LOGN     = 8,
  parameter int RD_LAT   = 1,
  parameter int BFU_LAT  = 4,
  parameter int PIPE_LAT = RD_LAT + BFU_LAT
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic            i_intt,
  input  logic            i_algo,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_rd_en,
  output logic [LOGN-1:0] o_rd_addr_a,
  output logic [LOGN-1:0] o_rd_addr_b,
  output logic [LOGN-1:0] o_tw_idx,
  output logic            o_bfu_intt,
  output logic            o_bfu_algo,
  output logic            o_bfu_skip,
  output logic            o_wr_en,
  output logic [LOGN-1:0] o_wr_addr_a,
  output logic [LOGN-1:0] o_wr_addr_b
);

  localparam int BFW = LOGN - 1;
  localparam int SW  = $clog2(LOGN);
  localparam int DW  = $clog2(PIPE_LAT);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [LOGN:0] c_N   = (LOGN+1)'(N);
  localparam logic [LOGN:0] c_ONE = (LOGN+1)'(1);

  logic [2:0]      r_state;
  logic [2:0]      w_next;
  logic [BFW-1:0]  r_bf;
  logic [SW-1:0]   r_layer;
  logic [DW-1:0]   r_drain;
  logic            r_intt;
  logic            r_algo;

  logic [PIPE_LAT-1:0] r_pv;
  logic [LOGN-1:0]     r_pa [PIPE_LAT];
  logic [LOGN-1:0]     r_pb [PIPE_LAT];

  logic            w_bf_last;
  logic            w_last_layer;
  logic            w_drain_last;
  logic            w_flush_last;
  logic [SW-1:0]   w_shift;
  logic [LOGN-1:0] w_bf_x;
  logic [LOGN-1:0] w_len;
  logic [LOGN-1:0] w_grp;
  logic [LOGN-1:0] w_off;
  logic [LOGN-1:0] w_addr_a;
  logic [LOGN-1:0] w_addr_b;
  logic [LOGN-1:0] w_tw;

  assign w_bf_last    = &r_bf;
  assign w_last_layer = (r_layer == (r_algo ? SW'(LOGN-1) : SW'(LOGN-2)));
  assign w_drain_last = (r_drain == DW'(PIPE_LAT-1));
  // The final write is the only thing left in the delay line.
  assign w_flush_last = r_pv[PIPE_LAT-1] && (r_pv[PIPE_LAT-2:0] == '0);

  // Forward runs len from N/2 down; inverse runs up, Kyber starting at len=2.
  assign w_shift  = r_intt ? (r_layer + {{(SW-1){1'b0}}, ~r_algo})
                           : (SW'(LOGN-1) - r_layer);
  assign w_bf_x   = LOGN'(r_bf);
  assign w_len    = LOGN'(1) << w_shift;
  assign w_grp    = w_bf_x >> w_shift;
  assign w_off    = w_bf_x & (w_len - LOGN'(1));
  assign w_addr_a = ((w_grp << w_shift) << 1) | w_off;
  assign w_addr_b = w_addr_a + w_len;
  assign w_tw     = r_intt ? (LOGN'((c_N >> w_shift) - c_ONE) - w_grp)
                           : ((LOGN'(N/2) >> w_shift) + w_grp);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_ISSUE;
      S_ISSUE: if (w_bf_last) w_next = w_last_layer ? S_FLUSH : S_DRAIN;
      S_DRAIN: if (w_drain_last) w_next = S_ISSUE;
      S_FLUSH: if (w_flush_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bf    <= '0;
      r_layer <= '0;
      r_drain <= '0;
      r_intt  <= 1'b0;
      r_algo  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_intt  <= i_intt;
            r_algo  <= i_algo;
            r_bf    <= '0;
            r_layer <= '0;
            r_drain <= '0;
          end
        end
        S_ISSUE: begin
          r_bf <= r_bf + BFW'(1);
          if (w_bf_last && !w_last_layer) r_layer <= r_layer + SW'(1);
        end
        S_DRAIN: r_drain <= w_drain_last ? '0 : r_drain + DW'(1);
        S_DONE: begin
          r_intt <= 1'b0;
          r_algo <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pv <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        r_pa[i] <= '0;
        r_pb[i] <= '0;
      end
    end else begin
      r_pv    <= {r_pv[PIPE_LAT-2:0], o_rd_en};
      r_pa[0] <= o_rd_addr_a;
      r_pb[0] <= o_rd_addr_b;
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_pa[i] <= r_pa[i-1];
        r_pb[i] <= r_pb[i-1];
      end
    end
  end

  always_comb begin
    o_busy      = (r_state != S_IDLE);
    o_done      = (r_state == S_DONE);
    o_rd_en     = (r_state == S_ISSUE);
    o_rd_addr_a = o_rd_en ? w_addr_a : '0;
    o_rd_addr_b = o_rd_en ? w_addr_b : '0;
    o_tw_idx    = o_rd_en ? w_tw : '0;
    o_bfu_intt  = r_intt;
    o_bfu_algo  = r_algo;
    o_bfu_skip  = 1'b0;
    o_wr_en     = r_pv[PIPE_LAT-1];
    o_wr_addr_a = r_pa[PIPE_LAT-1];
    o_wr_addr_b = r_pb[PIPE_LAT-1];
  end

endmodule
`default_nettype wire

// File: tb/tb_ntt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ntt_ctrl
// Purpose  : Scoreboard bench for ntt_ctrl against a loop-nest NTT reference
// Revision : 1.0
// ============================================================================
module tb_ntt_ctrl;

  localparam int PIPE   = 5;
  localparam int PERIOD = 128 + PIPE;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic       i_intt = 1'b0;
  logic       i_algo = 1'b0;
  logic       o_busy, o_done, o_rd_en, o_bfu_intt, o_bfu_algo, o_bfu_skip, o_wr_en;
  logic [7:0] o_rd_addr_a, o_rd_addr_b, o_tw_idx, o_wr_addr_a, o_wr_addr_b;

  ntt_ctrl dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_intt(i_intt),
    .i_algo(i_algo), .o_busy(o_busy), .o_done(o_done), .o_rd_en(o_rd_en),
    .o_rd_addr_a(o_rd_addr_a), .o_rd_addr_b(o_rd_addr_b), .o_tw_idx(o_tw_idx),
    .o_bfu_intt(o_bfu_intt), .o_bfu_algo(o_bfu_algo), .o_bfu_skip(o_bfu_skip),
    .o_wr_en(o_wr_en), .o_wr_addr_a(o_wr_addr_a), .o_wr_addr_b(o_wr_addr_b)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct { int cyc; int a; int b; int tw; int intt; int algo; } rd_t;
  typedef struct { int cyc; int a; int b; } wr_t;

  rd_t rq[$];
  wr_t wq[$];
  int  dq[$];
  int  wnq[$];
  rd_t r_exp;
  wr_t w_exp;
  int  pend [256];
  int  n_checks = 0;
  int  n_pass = 0;
  int  b_lo = 1, b_hi = 0, busy_end = 0;
  int  wr_seen = 0;
  int  last_c0 = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference: textbook NTT loop nest with a running twiddle counter k.
  task automatic push_op(input int intt, input int algo, input int c0);
    int nl, len, k, idx, t;
    rd_t r;
    wr_t w;
    nl = algo ? 8 : 7;
    k  = intt ? (algo ? 255 : 127) : 1;
    for (int l = 0; l < nl; l++) begin
      len = intt ? ((algo ? 1 : 2) << l) : (128 >> l);
      idx = 0;
      for (int st = 0; st < 256; st += 2 * len) begin
        for (int j = st; j < st + len; j++) begin
          t = c0 + 1 + l * PERIOD + idx;
          r = '{cyc: t, a: j, b: j + len, tw: k, intt: intt, algo: algo};
          w = '{cyc: t + PIPE, a: j, b: j + len};
          rq.push_back(r);
          wq.push_back(w);
          idx++;
        end
        k = intt ? k - 1 : k + 1;
      end
    end
    t = c0 + 1 + (nl - 1) * PERIOD + 127 + PIPE + 1;
    dq.push_back(t);
    wnq.push_back(128 * nl);
    b_lo     = c0 + 1;
    b_hi     = t;
    busy_end = t + 1;
  endtask

  always @(negedge i_clk) begin
    if (i_rst_n) begin
      chk("busy", int'(o_busy), int'(cyc >= b_lo && cyc <= b_hi));
      if (o_wr_en) begin
        if (wq.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          w_exp = wq.pop_front();
          chk("wr_cycle", cyc, w_exp.cyc);
          chk("wr_addr_a", int'(o_wr_addr_a), w_exp.a);
          chk("wr_addr_b", int'(o_wr_addr_b), w_exp.b);
        end
        pend[o_wr_addr_a]--;
        pend[o_wr_addr_b]--;
        wr_seen++;
      end
      if (o_rd_en) begin
        chk("hazard_a", pend[o_rd_addr_a], 0);
        chk("hazard_b", pend[o_rd_addr_b], 0);
        if (rq.size() == 0) chk("unexpected_read", 1, 0);
        else begin
          r_exp = rq.pop_front();
          chk("rd_cycle", cyc, r_exp.cyc);
          chk("rd_addr_a", int'(o_rd_addr_a), r_exp.a);
          chk("rd_addr_b", int'(o_rd_addr_b), r_exp.b);
          chk("tw_idx", int'(o_tw_idx), r_exp.tw);
          chk("bfu_intt", int'(o_bfu_intt), r_exp.intt);
          chk("bfu_algo", int'(o_bfu_algo), r_exp.algo);
          chk("bfu_skip", int'(o_bfu_skip), 0);
        end
        pend[o_rd_addr_a]++;
        pend[o_rd_addr_b]++;
      end
      if (o_done) begin
        if (dq.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          chk("done_cycle", cyc, dq.pop_front());
          chk("write_count", wr_seen, wnq.pop_front());
        end
        wr_seen = 0;
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic issue_start(input int intt, input int algo);
    @(posedge i_clk);
    #1;
    i_start = 1'b1;
    i_intt  = 1'(intt);
    i_algo  = 1'(algo);
    if (cyc >= busy_end) begin
      last_c0 = cyc;
      push_op(intt, algo, cyc);
    end
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    i_intt  = 1'($urandom);
    i_algo  = 1'($urandom);
  endtask

  task automatic finish_op();
    wait_until(busy_end + 3);
    chk("rd_leftover", rq.size(), 0);
    chk("wr_leftover", wq.size(), 0);
    chk("done_leftover", dq.size(), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, int'(o_busy), 0);
    chk({tag, "_done"}, int'(o_done), 0);
    chk({tag, "_rd_en"}, int'(o_rd_en), 0);
    chk({tag, "_rd_a"}, int'(o_rd_addr_a), 0);
    chk({tag, "_rd_b"}, int'(o_rd_addr_b), 0);
    chk({tag, "_tw"}, int'(o_tw_idx), 0);
    chk({tag, "_bintt"}, int'(o_bfu_intt), 0);
    chk({tag, "_balgo"}, int'(o_bfu_algo), 0);
    chk({tag, "_skip"}, int'(o_bfu_skip), 0);
    chk({tag, "_wr_en"}, int'(o_wr_en), 0);
    chk({tag, "_wr_a"}, int'(o_wr_addr_a), 0);
    chk({tag, "_wr_b"}, int'(o_wr_addr_b), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) pend[i] = 0;
    repeat (3) @(posedge i_clk);
    #1;
    chk_zero("reset");
    @(posedge i_clk);
    #3;
    i_rst_n = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;

    // Four directed modes: Dilithium/Kyber, forward/inverse.
    issue_start(0, 1); finish_op();
    issue_start(0, 0); finish_op();
    issue_start(1, 1); finish_op();
    issue_start(1, 0); finish_op();

    // Start while busy is ignored; start in the cycle busy drops is taken.
    issue_start(0, 0);
    wait_until(cyc + int'($urandom_range(10, 600)));
    issue_start(1, 1);
    wait_until(busy_end - 1);
    issue_start(1, 1);
    finish_op();

    for (int n = 0; n < 4; n++) begin
      wait_until(cyc + int'($urandom_range(0, 7)));
      issue_start(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
      if (($urandom & 1) != 0) begin
        wait_until(cyc + int'($urandom_range(1, 300)));
        issue_start(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
      end
      finish_op();
    end

    // Asynchronous reset mid-INTT, then a fresh operation.
    issue_start(1, int'($urandom_range(0, 1)));
    wait_until(last_c0 + 299);
    @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    rq.delete();
    wq.delete();
    dq.delete();
    wnq.delete();
    for (int i = 0; i < 256; i++) pend[i] = 0;
    b_hi = 0;
    busy_end = 0;
    wr_seen = 0;
    repeat (2) @(posedge i_clk);
    #3;
    i_rst_n = 1'b1;
    wait_until(cyc + 20);
    issue_start(0, int'($urandom_range(0, 1)));
    finish_op();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
